// File: rtl/ibus_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common (package)
// Description : Shared instruction-bus types, responder FSM states and the NOP
//               word returned for unmapped fetches.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } ibus_resp_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/ibus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ibus_mem_responder_if
// Description : Instruction-bus request/response bundle with fetch-side
//               (master) and memory-side (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibus_mem_responder_if;
    import common::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input  iresp);
    modport slave  (input  ireq, output iresp);

endinterface
`default_nettype wire

// File: rtl/ibus_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : ibus_mem_array
// Description : DEPTH_WORDS x 32 synchronous array, one read and one write
//               port, read-before-write on a shared word.
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_mem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_rd_en,
    input  wire logic [IDX_W-1:0] i_rd_idx,
    output logic      [31:0]      o_rd_data,
    input  wire logic             i_wr_en,
    input  wire logic [IDX_W-1:0] i_wr_idx,
    input  wire logic [31:0]      i_wr_data
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_data <= 32'd0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibus_mem_responder
// Description : Memory-side instruction-bus responder: one fetch at a time,
//               fixed-latency data_ok pulse, backdoor program load port.
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_mem_responder
    import common::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    ibus_mem_responder_if.slave                 bus,
    input  wire logic                           load_en,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  wire logic [31:0]                    load_data
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [63:0] C_SPAN     = 64'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  C_CNT_INIT = 4'(LATENCY - 1);
    localparam bit          C_DIRECT   = (LATENCY == 1);

    ibus_resp_state_t r_state;
    ibus_resp_state_t w_state_nxt;
    logic [3:0]       r_cnt;
    logic [63:0]      r_addr;
    logic             r_oor;

    logic             w_addr_ok;
    logic             w_data_ok;
    logic             w_accept;
    logic             w_rd_en;
    logic [63:0]      w_addr_sel;
    logic [63:0]      w_off;
    logic             w_oor;
    logic [IDX_W-1:0] w_rd_idx;
    logic [31:0]      w_rd_data;

    // With LATENCY==1 the read happens on the handshake edge, so decode the
    // live request address in IDLE and the latched one otherwise.
    assign w_addr_sel = (r_state == IDLE) ? bus.ireq.addr : r_addr;
    assign w_off      = w_addr_sel - BASE_ADDR;
    assign w_oor      = (w_addr_sel < BASE_ADDR) || (w_off >= C_SPAN);
    assign w_rd_idx   = w_off[IDX_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 64'd0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= bus.ireq.addr;
                r_cnt  <= C_CNT_INIT;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_rd_en) begin
                r_oor <= w_oor;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_ok   = 1'b0;
        w_data_ok   = 1'b0;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                w_addr_ok = bus.ireq.valid;
                if (bus.ireq.valid) begin
                    w_accept = 1'b1;
                    if (C_DIRECT) begin
                        w_rd_en     = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // Counter reaches zero on this edge: capture the word now.
                if (r_cnt == 4'd1) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_data_ok   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    ibus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .i_wr_en   (load_en),
        .i_wr_idx  (load_idx),
        .i_wr_data (load_data)
    );

    assign bus.iresp = '{addr_ok: w_addr_ok,
                         data_ok: w_data_ok,
                         data:    (r_oor ? NOP_INST : w_rd_data)};

endmodule
`default_nettype wire

// File: tb/tb_ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibus_mem_responder
// Description : Self-checking bench for ibus_mem_responder with a timeline
//               model of the fetch protocol and directed fetch scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibus_mem_responder;
    import common::*;

    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        valid     = 1'b0;
    logic [63:0] addr      = 64'd0;
    logic        load_en   = 1'b0;
    logic [11:0] load_idx  = 12'd0;
    logic [31:0] load_data = 32'd0;

    ibus_mem_responder_if bus();
    assign bus.ireq = '{valid: valid, addr: addr};

    ibus_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: c is the current cycle index; a request accepted in
    // cycle R answers in cycle R+LAT with the word as it stood at the start
    // of that cycle.
    logic [31:0] mmem [DEPTH];
    bit          busy    = 1'b0;
    longint      c       = 0;
    longint      resp_at = 0;
    logic [63:0] haddr   = 64'd0;
    logic [31:0] m_data  = 32'd0;

    function automatic logic [31:0] lookup(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        if (a < BASE || off >= 64'(DEPTH) * 4) return NOP_INST;
        return mmem[off[13:2]];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   = 1'b0;
            m_data = 32'd0;
        end else begin
            if (!busy && valid) begin
                busy    = 1'b1;
                resp_at = c + LAT;
                haddr   = addr;
            end
            if (busy && c + 1 == resp_at) m_data = lookup(haddr);
            if (busy && c == resp_at) busy = 1'b0;
            if (load_en) mmem[load_idx] = load_data;
            c++;
        end
    end

    always @(negedge clk) begin
        check("addr_ok", 64'(bus.iresp.addr_ok), 64'(valid && !busy));
        check("data_ok", 64'(bus.iresp.data_ok), 64'(busy && c == resp_at));
        check("data",    64'(bus.iresp.data),    64'(m_data));
    end

    task automatic load(input logic [11:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_idx = idx; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic wait_accept(output longint t, output logic [31:0] seen);
        bit ok = 1'b0;
        seen = 32'd0;
        t    = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.iresp.data_ok) seen = bus.iresp.data;
            if (bus.iresp.addr_ok) begin
                ok = 1'b1;
                t  = c;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_resp(output logic [31:0] d, output int lat);
        bit ok = 1'b0;
        d   = 32'd0;
        lat = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            lat++;
            if (bus.iresp.data_ok) begin
                ok = 1'b1;
                d  = bus.iresp.data;
            end
        end
        if (!ok) check("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic fetch(input logic [63:0] a, output logic [31:0] d, output int lat);
        longint      t;
        logic [31:0] seen;
        @(posedge clk); #1;
        valid = 1'b1; addr = a;
        wait_accept(t, seen);
        @(posedge clk); #1;
        valid = 1'b0;
        wait_resp(d, lat);
    endtask

    initial begin
        logic [31:0] d, d0, d1, seen;
        int          lat, n_ok;
        longint      t0, t1;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr_ok", 64'(bus.iresp.addr_ok), 64'd0);
        check("rst_data_ok", 64'(bus.iresp.data_ok), 64'd0);
        check("rst_data",    64'(bus.iresp.data),    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        load(12'd0, 32'h0010_0093);
        fetch(BASE, d, lat);
        check("first_latency", 64'(lat), 64'd2);
        check("first_data",    64'(d),   64'h0010_0093);

        // Valid held high across two fetches.
        load(12'd0, 32'h11);
        load(12'd1, 32'h22);
        @(posedge clk); #1;
        valid = 1'b1; addr = BASE;
        wait_accept(t0, seen);
        @(posedge clk); #1;
        addr = BASE + 64'd4;
        wait_accept(t1, d0);
        @(posedge clk); #1;
        valid = 1'b0;
        wait_resp(d1, lat);
        check("b2b_spacing", 64'(t1 - t0), 64'd3);
        check("b2b_data0",   64'(d0),      64'h11);
        check("b2b_data1",   64'(d1),      64'h22);

        fetch(64'h7FFF_FFFC, d, lat);
        check("oor_low",  64'(d), 64'h13);
        fetch(BASE + 64'(DEPTH) * 4, d, lat);
        check("oor_high", 64'(d), 64'h13);

        load(12'd1, 32'hDEAD_BEEF);
        fetch(BASE + 64'd6, d, lat);
        check("misaligned", 64'(d), 64'hDEAD_BEEF);

        // Backdoor write lands on the same edge that captures the read.
        load(12'd3, 32'h44);
        @(posedge clk); #1;
        valid = 1'b1; addr = BASE + 64'd12;
        @(negedge clk);
        check("rbw_addr_ok", 64'(bus.iresp.addr_ok), 64'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        load_en = 1'b1; load_idx = 12'd3; load_data = 32'h55;
        @(posedge clk); #1;
        load_en = 1'b0;
        @(negedge clk);
        check("rbw_data_ok", 64'(bus.iresp.data_ok), 64'd1);
        check("rbw_old",     64'(bus.iresp.data),    64'h44);
        fetch(BASE + 64'd12, d, lat);
        check("rbw_new", 64'(d), 64'h55);

        // Reset during BUSY drops the in-flight response.
        @(posedge clk); #1;
        valid = 1'b1; addr = BASE;
        @(negedge clk);
        @(posedge clk); #1;
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_ok = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.iresp.data_ok) n_ok++;
        end
        check("rst_mid_no_resp", 64'(n_ok), 64'd0);
        @(posedge clk); #1;
        valid = 1'b1; addr = BASE + 64'd4;
        @(negedge clk);
        check("rst_mid_idle", 64'(bus.iresp.addr_ok), 64'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        wait_resp(d, lat);
        check("rst_mid_latency", 64'(lat), 64'd2);
        check("rst_mid_data",    64'(d),   64'hDEAD_BEEF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
